line_recovery_ctrl: RTL and testbench
=====================================

# line_recovery_ctrl

Recovery stage between the line-tracker decoder and the motor driver. In normal tracking it passes the tracker's motion mode straight through to the motor. When all three track sensors lose the line for longer than a debounce window, it spins toward the side where the line was last seen. If the line is not reacquired within a timeout, it stops the kart and flags a failure.

## Interface
- `LOST_DEBOUNCE`, default 2_000_000: consecutive all-off cycles (20 ms at 100 MHz) before search starts; minimum 1.
- `SEARCH_TIMEOUT`, default 200_000_000: maximum cycles spent in search (2 s at 100 MHz); minimum 1.
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  high while the top FSM is in GO; low forces stop and clears recovery state.
- `left_track`, `mid_track`, `right_track`  in  1 each  raw asynchronous sensor inputs; 1 = line detected.
- `track_mode_in`  in  3  motion mode from `tracker_sensor`.
- `mode_out`  out  3  motion mode to `motor`.
- `lost`  out  1  high in LOST_WAIT or SEARCH.
- `search_fail`  out  1  high in FAIL.
- `state_dbg`  out  2  current state encoding, for the LED/seven-segment debug display.

## Operation
- Mode encoding, shared with `motor`:
  - 000 stop, 001 forward, 010 left, 011 right, 100 sharp left, 101 sharp right.
  - 110 and 111 are reserved; a reserved value on `track_mode_in` is output as 000.
- Sensor inputs pass through a 2-flop synchronizer each. Call the synchronized vector `s = {l, m, r}`. "Seen" means any bit of `s` is 1.
- `last_dir` register, updated only in TRACK:
  - `s` = 100 or 110 → LEFT.
  - `s` = 001 or 011 → RIGHT.
  - Any other value → unchanged.
  - Reset value: LEFT.
- States (`state_dbg`): TRACK = 00, LOST_WAIT = 01, SEARCH = 10, FAIL = 11.
- TRACK:
  - `mode_out` ← `track_mode_in` (after the reserved-value filter).
  - `s` = 000 → LOST_WAIT, lost counter loaded with 1.
- LOST_WAIT:
  - `mode_out` holds its previous value.
  - Seen → TRACK.
  - Otherwise the counter increments. When the counter equals `LOST_DEBOUNCE` → SEARCH and the search counter is cleared.
- SEARCH:
  - `mode_out` = 100 if `last_dir` = LEFT, 101 if RIGHT.
  - Seen → TRACK.
  - Otherwise the search counter increments. When it equals `SEARCH_TIMEOUT - 1` → FAIL.
- FAIL:
  - `mode_out` = 000.
  - Exits only when `enable` goes low, or on `rst`.
- `enable` low has priority over every transition:
  - Next state is TRACK, both counters are cleared, `mode_out` = 000.
  - `last_dir` is retained.
- If "seen" and a counter-terminal condition occur in the same cycle, "seen" wins and the next state is TRACK.
- Counter width is `$clog2(max(LOST_DEBOUNCE, SEARCH_TIMEOUT) + 1)`. Counters never wrap; they are cleared on every state entry.

## Timing
- All outputs are registered.
- Reset values: `mode_out` = 000, `lost` = 0, `search_fail` = 0, `state_dbg` = 00, state = TRACK, counters = 0, `last_dir` = LEFT.
- Latencies:
  - `track_mode_in` → `mode_out`: 1 cycle in TRACK.
  - Raw sensor edge → state change: 3 cycles (2 synchronizer cycles + 1 state register).
  - `mode_out`, `lost`, `search_fail` and `state_dbg` reflect the new state in the cycle it is entered; they are decoded from next-state.
- Timeline from the first synchronized all-off sample in TRACK:
  - Next cycle: LOST_WAIT, `lost` = 1.
  - `LOST_DEBOUNCE` cycles later: SEARCH, sharp-turn mode.
  - `SEARCH_TIMEOUT` cycles in SEARCH, then FAIL.
- `enable` falling: `mode_out` = 000 on the next edge, in every state.
- `rst` mid-search: state returns to reset values on the next edge, including `last_dir`.

## Test plan
Bench parameters: `LOST_DEBOUNCE` = 4, `SEARCH_TIMEOUT` = 10.

1. **Pass-through.** `enable` = 1, sensors 010, `track_mode_in` stepping 001 → 010 → 011 → 110. `mode_out` follows 1 cycle later as 001, 010, 011, 000; `state_dbg` stays 00.
2. **Debounce reject.** Sensors 011, then 000 for 3 cycles, then 010. `state_dbg` goes 01 and returns to 00 without ever reaching 10; `mode_out` holds 011 throughout LOST_WAIT.
3. **Search right and reacquire.**
   - Sensors 001 (`last_dir` = RIGHT), then 000 held.
   - `state_dbg` = 10 and `mode_out` = 101 exactly 4 cycles after LOST_WAIT entry.
   - Sensor 100 at search cycle 5 → `state_dbg` = 00 three cycles later; `mode_out` = `track_mode_in`.
4. **Timeout.**
   - Sensors 100 then 000 held.
   - `mode_out` = 100 in SEARCH.
   - After 10 SEARCH cycles: `state_dbg` = 11, `search_fail` = 1, `mode_out` = 000, held for 50 further cycles.
   - `enable` = 0 → `state_dbg` = 00.
5. **Enable override.** `enable` dropped mid-SEARCH. Next edge: `mode_out` = 000, `lost` = 0, `state_dbg` = 00. Re-raising `enable` with sensors 000 restarts debounce from count 1.
6. **Simultaneous events.**
   - Sensor becomes seen in the same cycle the search counter hits terminal → next state TRACK, not FAIL.
   - `rst` asserted in SEARCH → all outputs take reset values next edge; `last_dir` = LEFT.

Source files
------------

// File: rtl/line_recovery_ctrl.sv
// Line-loss recovery between the tracker decoder and the motor driver.
// Passes the tracker mode through, spins toward the last-seen side on loss, stops on timeout.
module line_recovery_ctrl #(
  parameter int unsigned LOST_DEBOUNCE  = 2_000_000,
  parameter int unsigned SEARCH_TIMEOUT = 200_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       left_track,
  input  logic       mid_track,
  input  logic       right_track,
  input  logic [2:0] track_mode_in,
  output logic [2:0] mode_out,
  output logic       lost,
  output logic       search_fail,
  output logic [1:0] state_dbg
);

  localparam int unsigned CNT_MAX =
    (LOST_DEBOUNCE > SEARCH_TIMEOUT) ? LOST_DEBOUNCE : SEARCH_TIMEOUT;
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] LOST_END   = CW'(LOST_DEBOUNCE);
  localparam logic [CW-1:0] SEARCH_END = CW'(SEARCH_TIMEOUT - 1);

  localparam logic [2:0] M_STOP   = 3'b000;
  localparam logic [2:0] M_SLEFT  = 3'b100;
  localparam logic [2:0] M_SRIGHT = 3'b101;

  typedef enum logic [1:0] {
    TRACK     = 2'b00,
    LOST_WAIT = 2'b01,
    SEARCH    = 2'b10,
    FAIL      = 2'b11
  } state_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_t;

  logic [2:0]    sync1;
  logic [2:0]    s;
  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  dir_t          last_dir;
  dir_t          dir_n;
  logic [2:0]    mode_in;
  logic [2:0]    mode_n;
  logic          lost_n;
  logic          fail_n;
  logic          seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 3'b000;
      s     <= 3'b000;
    end else begin
      sync1 <= {left_track, mid_track, right_track};
      s     <= sync1;
    end
  end

  assign seen    = |s;
  assign mode_in = (track_mode_in > 3'd5) ? M_STOP : track_mode_in;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dir_n   = last_dir;
    if (!enable) begin
      state_n = TRACK;
      cnt_n   = '0;
    end else begin
      unique case (state)
        TRACK: begin
          unique case (s)
            3'b100, 3'b110: dir_n = LEFT;
            3'b001, 3'b011: dir_n = RIGHT;
            default:        dir_n = last_dir;
          endcase
          if (!seen) begin
            state_n = LOST_WAIT;
            cnt_n   = CW'(1);
          end
        end
        LOST_WAIT: begin
          if (seen) begin
            state_n = TRACK;
            cnt_n   = '0;
          end else if (cnt == LOST_END) begin
            state_n = SEARCH;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        SEARCH: begin
          // a reacquired line beats the timeout in the same cycle
          if (seen) begin
            state_n = TRACK;
            cnt_n   = '0;
          end else if (cnt == SEARCH_END) begin
            state_n = FAIL;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        FAIL: begin
          state_n = FAIL;
        end
        default: begin
          state_n = TRACK;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // outputs are decoded from the next state so they land with it
  always_comb begin
    mode_n = mode_out;
    lost_n = 1'b0;
    fail_n = 1'b0;
    unique case (state_n)
      TRACK:     mode_n = enable ? mode_in : M_STOP;
      LOST_WAIT: lost_n = 1'b1;
      SEARCH: begin
        lost_n = 1'b1;
        mode_n = (last_dir == RIGHT) ? M_SRIGHT : M_SLEFT;
      end
      FAIL: begin
        fail_n = 1'b1;
        mode_n = M_STOP;
      end
      default: mode_n = M_STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= TRACK;
      cnt         <= '0;
      last_dir    <= LEFT;
      mode_out    <= M_STOP;
      lost        <= 1'b0;
      search_fail <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      last_dir    <= dir_n;
      mode_out    <= mode_n;
      lost        <= lost_n;
      search_fail <= fail_n;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_line_recovery_ctrl.sv
// Directed bench for line_recovery_ctrl.
// Uses LOST_DEBOUNCE = 4 and SEARCH_TIMEOUT = 10.
module tb_line_recovery_ctrl;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       left_track;
  logic       mid_track;
  logic       right_track;
  logic [2:0] track_mode_in;
  logic [2:0] mode_out;
  logic       lost;
  logic       search_fail;
  logic [1:0] state_dbg;

  int checks;
  int failures;
  int bad;

  line_recovery_ctrl #(
    .LOST_DEBOUNCE (4),
    .SEARCH_TIMEOUT(10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .left_track   (left_track),
    .mid_track    (mid_track),
    .right_track  (right_track),
    .track_mode_in(track_mode_in),
    .mode_out     (mode_out),
    .lost         (lost),
    .search_fail  (search_fail),
    .state_dbg    (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_s(input logic [2:0] v);
    {left_track, mid_track, right_track} = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    enable   = 1'b0;
    track_mode_in = 3'b000;
    set_s(3'b010);
    tick(3);
    check("rst_mode", mode_out, 0);
    check("rst_lost", lost, 0);
    check("rst_fail", search_fail, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;
    tick(3);

    // pass-through
    enable = 1'b1;
    track_mode_in = 3'b001; tick;
    check("pt_001", mode_out, 3'b001);
    track_mode_in = 3'b010; tick;
    check("pt_010", mode_out, 3'b010);
    track_mode_in = 3'b011; tick;
    check("pt_011", mode_out, 3'b011);
    track_mode_in = 3'b110; tick;
    check("pt_110", mode_out, 3'b000);
    check("pt_state", state_dbg, 0);

    // debounce reject
    track_mode_in = 3'b011;
    set_s(3'b011); tick(3);
    check("db_mode0", mode_out, 3'b011);
    set_s(3'b000); tick(3);
    check("db_lw", state_dbg, 1);
    check("db_lost", lost, 1);
    check("db_hold0", mode_out, 3'b011);
    set_s(3'b010); tick;
    check("db_lw1", state_dbg, 1);
    check("db_hold1", mode_out, 3'b011);
    tick;
    check("db_lw2", state_dbg, 1);
    tick;
    check("db_back", state_dbg, 0);
    check("db_unlost", lost, 0);

    // search right, reacquire
    track_mode_in = 3'b001;
    set_s(3'b001); tick(3);
    set_s(3'b000); tick(3);
    check("sr_lw", state_dbg, 1);
    tick(3);
    check("sr_lw3", state_dbg, 1);
    tick;
    check("sr_search", state_dbg, 2);
    check("sr_mode", mode_out, 3'b101);
    check("sr_lost", lost, 1);
    tick(4);
    track_mode_in = 3'b010;
    set_s(3'b100); tick(2);
    check("sr_still", state_dbg, 2);
    check("sr_still_m", mode_out, 3'b101);
    tick;
    check("sr_reacq", state_dbg, 0);
    check("sr_pt", mode_out, 3'b010);
    check("sr_unlost", lost, 0);

    // timeout
    set_s(3'b000); tick(3);
    check("to_lw", state_dbg, 1);
    tick(4);
    check("to_search", state_dbg, 2);
    check("to_mode", mode_out, 3'b100);
    tick(9);
    check("to_last", state_dbg, 2);
    tick;
    check("to_fail", state_dbg, 3);
    check("to_flag", search_fail, 1);
    check("to_stop", mode_out, 3'b000);
    check("to_lost", lost, 0);
    bad = 0;
    repeat (50) begin
      tick;
      if (state_dbg !== 2'd3 || mode_out !== 3'b000 || search_fail !== 1'b1)
        bad++;
    end
    check("to_hold", bad, 0);
    enable = 1'b0; tick;
    check("to_exit", state_dbg, 0);
    check("to_exit_f", search_fail, 0);
    check("to_exit_m", mode_out, 3'b000);

    // enable override
    enable = 1'b1; tick;
    check("en_lw", state_dbg, 1);
    tick(4);
    check("en_search", state_dbg, 2);
    tick(2);
    enable = 1'b0; tick;
    check("en_mode", mode_out, 3'b000);
    check("en_lost", lost, 0);
    check("en_state", state_dbg, 0);
    enable = 1'b1; tick;
    check("en_re_lw", state_dbg, 1);
    check("en_re_lost", lost, 1);
    tick(3);
    check("en_re_lw3", state_dbg, 1);
    tick;
    check("en_re_srch", state_dbg, 2);
    check("en_re_mode", mode_out, 3'b100);

    // seen on the terminal cycle
    track_mode_in = 3'b011;
    tick(7);
    set_s(3'b010); tick(2);
    check("sim_still", state_dbg, 2);
    tick;
    check("sim_track", state_dbg, 0);
    check("sim_nofail", search_fail, 0);
    check("sim_mode", mode_out, 3'b011);

    // reset mid-search
    set_s(3'b001); tick(3);
    set_s(3'b000); tick(3);
    check("rs_lw", state_dbg, 1);
    tick(4);
    check("rs_search", state_dbg, 2);
    check("rs_right", mode_out, 3'b101);
    tick(2);
    rst = 1'b1; tick;
    check("rs_mode", mode_out, 0);
    check("rs_lost", lost, 0);
    check("rs_fail", search_fail, 0);
    check("rs_state", state_dbg, 0);
    rst = 1'b0; tick;
    check("rs_lw2", state_dbg, 1);
    tick(4);
    check("rs_srch2", state_dbg, 2);
    check("rs_dir", mode_out, 3'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
